// File: rtl/relu_col_scheduler.sv
// Round-robin scheduler that shares one ReLU clip unit among COL accumulator columns.
// Each column buffers up to two words. One clipped activation can leave per cycle.
module relu_col_scheduler #(
  parameter int unsigned COL    = 3,
  parameter int unsigned W_IN   = 32,
  parameter int unsigned W_DATA = 8,
  localparam int unsigned CW    = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [COL*W_IN-1:0] i_data,
  input  logic [COL-1:0]      i_data_valid,
  output logic [COL-1:0]      i_data_ready,
  input  logic [W_DATA-1:0]   cfg_clip,
  input  logic [15:0]         cfg_len,
  output logic [W_DATA-1:0]   o_data,
  output logic [CW-1:0]       o_col,
  output logic                o_data_valid,
  input  logic                o_ready,
  output logic                o_frame_done,
  output logic                o_busy
);

  logic [COL-1:0]  nonempty;
  logic [COL-1:0]  pop;
  logic [W_IN-1:0] head [COL];
  logic            load_en;
  logic            gnt_any;
  logic [CW-1:0]   gnt_idx;
  logic [W_IN-1:0] gnt_word;
  logic [CW-1:0]   rr_ptr;
  logic [CW:0]     scan;
  logic [15:0]     out_cnt;
  logic            xfer;
  logic            frame_end;

  // Per-column 2-entry FIFO. Ready depends only on occupancy, so a full FIFO stays not-ready during a pop.
  for (genvar c = 0; c < COL; c++) begin : g_fifo
    logic [W_IN-1:0] mem [2];
    logic [1:0]      cnt;
    logic            rd_ptr;
    logic            wr_ptr;
    logic            push;

    assign i_data_ready[c] = (cnt != 2'd2);
    assign nonempty[c]     = (cnt != 2'd0);
    assign push            = i_data_valid[c] & i_data_ready[c];
    assign head[c]         = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= i_data[c*W_IN +: W_IN];
          wr_ptr      <= ~wr_ptr;
        end
        if (pop[c]) begin
          rd_ptr <= ~rd_ptr;
        end
        cnt <= cnt + 2'(push) - 2'(pop[c]);
      end
    end
  end

  assign load_en = ~o_data_valid | o_ready;

  // Round-robin search. It starts at rr_ptr and wraps to column 0.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_word = '0;
    pop      = '0;
    scan     = '0;
    if (load_en) begin
      for (int unsigned k = 0; k < COL; k++) begin
        scan = {1'b0, rr_ptr} + (CW+1)'(k);
        if (scan >= (CW+1)'(COL)) begin
          scan = scan - (CW+1)'(COL);
        end
        if (!gnt_any && nonempty[scan[CW-1:0]]) begin
          gnt_any             = 1'b1;
          gnt_idx             = scan[CW-1:0];
          gnt_word            = head[scan[CW-1:0]];
          pop[scan[CW-1:0]]   = 1'b1;
        end
      end
    end
  end

  function automatic logic [W_DATA-1:0] relu_clip(input logic [W_IN-1:0] v,
                                                  input logic [W_DATA-1:0] lim);
    logic [W_DATA-1:0] r;
    if (v[W_IN-1]) begin
      r = '0;
    end else if (v > W_IN'(lim)) begin
      r = lim;
    end else begin
      r = v[W_DATA-1:0];
    end
    return r;
  endfunction

  // Output register. It holds while stalled and is cleared only when an empty slot is accepted downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_data       <= '0;
      o_col        <= '0;
      o_data_valid <= 1'b0;
      rr_ptr       <= '0;
    end else if (gnt_any) begin
      o_data       <= relu_clip(gnt_word, cfg_clip);
      o_col        <= gnt_idx;
      o_data_valid <= 1'b1;
      rr_ptr       <= (gnt_idx == CW'(COL - 1)) ? '0 : gnt_idx + CW'(1);
    end else if (o_ready) begin
      o_data_valid <= 1'b0;
    end
  end

  assign xfer      = o_data_valid & o_ready;
  assign frame_end = xfer && (cfg_len != 16'd0) && (out_cnt == cfg_len - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt      <= 16'd0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      if (xfer) begin
        out_cnt <= frame_end ? 16'd0 : out_cnt + 16'd1;
      end
    end
  end

  assign o_busy = (|nonempty) | o_data_valid;

endmodule

// File: tb/tb_relu_col_scheduler.sv
// Testbench for relu_col_scheduler. It runs table vectors, corner sequences and random traffic.
// A queue-level reference model is stepped once per clock edge.
module tb_relu_col_scheduler;
  localparam int unsigned COL    = 3;
  localparam int unsigned W_IN   = 32;
  localparam int unsigned W_DATA = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [COL*W_IN-1:0] i_data;
  logic [COL-1:0]      i_data_valid;
  logic [COL-1:0]      i_data_ready;
  logic [W_DATA-1:0]   cfg_clip;
  logic [15:0]         cfg_len;
  logic [W_DATA-1:0]   o_data;
  logic [1:0]          o_col;
  logic                o_data_valid;
  logic                o_ready;
  logic                o_frame_done;
  logic                o_busy;

  relu_col_scheduler #(.COL(COL), .W_IN(W_IN), .W_DATA(W_DATA)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_data_ready(i_data_ready), .cfg_clip(cfg_clip), .cfg_len(cfg_len),
    .o_data(o_data), .o_col(o_col), .o_data_valid(o_data_valid), .o_ready(o_ready),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: per-column word lists, output slot, round-robin start, frame count
  logic [31:0] mq [COL][2];
  int          msz [COL];
  bit          m_ov;
  bit          m_fd;
  logic [7:0]  m_od;
  int          m_col;
  int          m_rr;
  int          m_cnt;

  typedef struct {
    int          col;
    logic [31:0] word;
    logic [7:0]  clip;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clip_ref(input logic [31:0] w, input logic [7:0] lim);
    longint v;
    v = longint'($signed(w));
    if (v < 0) return 8'd0;
    if (v > longint'(lim)) return lim;
    return 8'(v);
  endfunction

  task automatic model_edge(input logic r, input logic [COL-1:0] v, input logic [COL*W_IN-1:0] d,
                            input logic ordy, input logic [7:0] clip, input logic [15:0] len);
    bit [COL-1:0] rdy;
    int g;
    logic [31:0] w;
    if (!r) begin
      for (int c = 0; c < COL; c++) msz[c] = 0;
      m_ov = 0; m_fd = 0; m_od = 8'd0; m_col = 0; m_rr = 0; m_cnt = 0;
      return;
    end
    for (int c = 0; c < COL; c++) rdy[c] = (msz[c] < 2);
    m_fd = 0;
    if (m_ov && ordy) begin
      if (len != 16'd0 && m_cnt == int'(len) - 1) begin
        m_fd = 1; m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
    g = -1;
    if (!m_ov || ordy) begin
      for (int k = 0; k < COL; k++) begin
        if (g < 0 && msz[(m_rr + k) % COL] > 0) g = (m_rr + k) % COL;
      end
    end
    if (g >= 0) begin
      w = mq[g][0];
      mq[g][0] = mq[g][1];
      msz[g]--;
      m_od = clip_ref(w, clip);
      m_col = g;
      m_ov = 1;
      m_rr = (g + 1) % COL;
    end else if (ordy) begin
      m_ov = 0;
    end
    for (int c = 0; c < COL; c++) begin
      if (v[c] && rdy[c]) begin
        mq[c][msz[c]] = d[c*W_IN +: W_IN];
        msz[c]++;
      end
    end
  endtask

  task automatic check_all();
    logic [COL-1:0] er;
    bit busy;
    busy = m_ov;
    for (int c = 0; c < COL; c++) begin
      er[c] = (msz[c] < 2);
      if (msz[c] > 0) busy = 1;
    end
    chk("o_data_valid", 64'(o_data_valid), 64'(m_ov));
    chk("o_data", 64'(o_data), 64'(m_od));
    chk("o_col", 64'(o_col), 64'(m_col));
    chk("o_frame_done", 64'(o_frame_done), 64'(m_fd));
    chk("i_data_ready", 64'(i_data_ready), 64'(er));
    chk("o_busy", 64'(o_busy), 64'(busy));
  endtask

  task automatic step();
    logic r, ordy;
    logic [COL-1:0] v;
    logic [COL*W_IN-1:0] d;
    logic [7:0] clip;
    logic [15:0] len;
    r = rst_n; v = i_data_valid; d = i_data; ordy = o_ready; clip = cfg_clip; len = cfg_len;
    @(posedge clk);
    model_edge(r, v, d, ordy, clip, len);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_data_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word(input logic [7:0] clip);
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = 32'($urandom_range(0, 300));
      1: w = 32'd0 - 32'($urandom_range(1, 1000));
      2: w = 32'($urandom);
      default: w = 32'(clip) + 32'($urandom_range(0, 2)) - 32'd1;
    endcase
    return w;
  endfunction

  initial begin
    int cnt;
    int pulses;
    logic [7:0] held;
    bit [COL-1:0] acc;

    tbl[0]  = '{1, 32'h0000_0032, 8'd100, 8'd50};
    tbl[1]  = '{0, 32'hFFFF_FFF6, 8'd100, 8'd0};
    tbl[2]  = '{1, 32'h0000_0BB8, 8'd100, 8'd100};
    tbl[3]  = '{2, 32'h0000_0064, 8'd100, 8'd100};
    tbl[4]  = '{0, 32'h0000_0065, 8'd100, 8'd100};
    tbl[5]  = '{2, 32'h0000_0063, 8'd100, 8'd99};
    tbl[6]  = '{1, 32'h8000_0000, 8'd255, 8'd0};
    tbl[7]  = '{0, 32'h7FFF_FFFF, 8'd255, 8'd255};
    tbl[8]  = '{2, 32'h0000_0005, 8'd0,   8'd0};
    tbl[9]  = '{1, 32'h0000_0000, 8'd0,   8'd0};
    tbl[10] = '{0, 32'h0000_00FF, 8'd200, 8'd200};
    tbl[11] = '{2, 32'h0000_00C8, 8'd200, 8'd200};

    rst_n = 1'b0; i_data = '0; i_data_valid = '0; cfg_clip = 8'd100; cfg_len = 16'd0; o_ready = 1'b1;
    do_reset();
    chk("reset_ready", 64'(i_data_ready), 64'h7);
    chk("reset_busy", 64'(o_busy), 64'h0);

    // Clip table: single word, two-edge latency, result and column
    for (int i = 0; i < 12; i++) begin
      cfg_clip = tbl[i].clip;
      i_data = '0;
      i_data[tbl[i].col*W_IN +: W_IN] = tbl[i].word;
      i_data_valid = '0;
      i_data_valid[tbl[i].col] = 1'b1;
      step();
      i_data_valid = '0;
      chk("tbl_lat_early", 64'(o_data_valid), 64'h0);
      step();
      chk("tbl_valid", 64'(o_data_valid), 64'h1);
      chk("tbl_data", 64'(o_data), 64'(tbl[i].exp));
      chk("tbl_col", 64'(o_col), 64'(tbl[i].col));
      step();
    end

    // Three columns at once: 0, 100, 100 on consecutive cycles
    do_reset();
    cfg_clip = 8'd100;
    i_data = {32'h0000_0064, 32'h0000_0BB8, 32'hFFFF_FFF6};
    i_data_valid = 3'b111;
    step();
    i_data_valid = '0;
    step(); chk("three_d0", 64'(o_data), 64'd0);   chk("three_c0", 64'(o_col), 64'd0);
    step(); chk("three_d1", 64'(o_data), 64'd100); chk("three_c1", 64'(o_col), 64'd1);
    step(); chk("three_d2", 64'(o_data), 64'd100); chk("three_c2", 64'(o_col), 64'd2);
    step();

    // All columns valid continuously: strict 0,1,2 rotation at one per cycle
    do_reset();
    cfg_clip = 8'd255;
    i_data_valid = 3'b111;
    for (int i = 0; i < 15; i++) begin
      i_data = {32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255))};
      step();
      if (i >= 1) begin
        chk("rr_valid", 64'(o_data_valid), 64'h1);
        chk("rr_col", 64'(o_col), 64'((i - 1) % 3));
      end
    end
    i_data_valid = '0;
    for (int i = 0; i < 8; i++) step();

    // Downstream stall: FIFOs fill, output holds, then 7 words drain
    do_reset();
    o_ready = 1'b0;
    i_data = {32'd12, 32'd11, 32'd10};
    i_data_valid = 3'b111;
    step(); step();
    held = o_data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", 64'(o_data), 64'(held));
    end
    chk("stall_held_val", 64'(held), 64'd10);
    chk("stall_ready", 64'(i_data_ready), 64'h0);
    i_data_valid = '0;
    o_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_data_valid) cnt++;
      step();
    end
    chk("stall_drain_cnt", 64'(cnt), 64'd7);

    // Frame pulses: cfg_len=4 -> 2 pulses in 10 transfers; cfg_len=0 -> none
    do_reset();
    cfg_len = 16'd4;
    pulses = 0;
    i_data_valid = 3'b001;
    for (int i = 0; i < 10; i++) begin
      i_data = '0; i_data[31:0] = 32'($urandom_range(0, 255));
      step();
      if (o_frame_done) pulses++;
    end
    i_data_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_frame_done) pulses++;
    end
    chk("frame_len4_pulses", 64'(pulses), 64'd2);
    cfg_len = 16'd0;
    pulses = 0;
    i_data_valid = 3'b010;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_frame_done) pulses++;
    end
    i_data_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_frame_done) pulses++;
    end
    chk("frame_len0_pulses", 64'(pulses), 64'd0);

    // Reset mid-stream discards everything, then column 0 has priority again
    do_reset();
    cfg_len = 16'd5;
    o_ready = 1'b0;
    i_data = {32'd3, 32'd2, 32'd1};
    i_data_valid = 3'b111;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    i_data_valid = '0;
    chk("rst_valid", 64'(o_data_valid), 64'h0);
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_col", 64'(o_col), 64'h0);
    chk("rst_fd", 64'(o_frame_done), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_ready", 64'(i_data_ready), 64'h7);
    o_ready = 1'b1;
    i_data_valid = 3'b101;
    step();
    i_data_valid = '0;
    step(); chk("rst_prio_c0", 64'(o_col), 64'd0);
    step(); chk("rst_prio_c2", 64'(o_col), 64'd2);
    step();

    // Random traffic against the model
    cfg_len = 16'd3;
    for (int c = 0; c < COL; c++) begin
      i_data[c*W_IN +: W_IN] = rand_word(cfg_clip);
      i_data_valid[c] = 1'b1;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 250 == 0) cfg_len = 16'($urandom_range(0, 6));
      if (cyc % 200 == 0) cfg_clip = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      o_ready = (cyc % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst_n = (cyc == 777) ? 1'b0 : 1'b1;
      for (int c = 0; c < COL; c++) acc[c] = i_data_valid[c] && (msz[c] < 2);
      step();
      for (int c = 0; c < COL; c++) begin
        if (acc[c] || !i_data_valid[c]) begin
          i_data_valid[c] = ($urandom_range(0, 2) != 0);
          i_data[c*W_IN +: W_IN] = rand_word(cfg_clip);
        end
      end
    end
    rst_n = 1'b1;
    i_data_valid = '0;
    o_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("final_idle", 64'(o_busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
